// File: rtl/ex_operand_forwarder.sv
// ---------------------------------------------------------------------------
// ex_operand_forwarder
//
// Consumer end of the MEM/WB forwarding path for the EX stage.
// For each EX source operand it picks, in priority order, the MEM forward
// value, the WB forward value, a locally held copy of the operand (valid only
// while EX is frozen and MEM/WB keep draining), or the register-file value
// latched into ID/EX. It also flags load-use hazards and keeps a saturating
// count of load-use stall cycles.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   pipe_stall                 global freeze: no internal state changes
//   ex_hold                    EX frozen while MEM/WB advance
//   ex_valid                   EX holds a real instruction
//   ex_sr1/ex_sr2, *_used      EX source registers and whether they are read
//   ex_rf_sr1/ex_rf_sr2        register-file values for the sources
//   mem_valid/regwrite/dest    MEM-stage destination description
//   mem_is_load, mem_resp      MEM op is a load / load data has returned
//   mem_fwd, wb_fwd            forward values from MEM and WB
//   wb_valid/regwrite/dest     WB-stage destination description
//   ex_opA, ex_opB             resolved operands (combinational)
//   ld_use_stall               EX needs a load value that has not returned yet
//   stall_count                saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module ex_operand_forwarder #(
    parameter int WIDTH     = 16,
    parameter int REG_BITS  = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_stall,
    input  logic                 ex_hold,
    input  logic                 ex_valid,
    input  logic [REG_BITS-1:0]  ex_sr1,
    input  logic                 ex_sr1_used,
    input  logic [REG_BITS-1:0]  ex_sr2,
    input  logic                 ex_sr2_used,
    input  logic [WIDTH-1:0]     ex_rf_sr1,
    input  logic [WIDTH-1:0]     ex_rf_sr2,
    input  logic                 mem_valid,
    input  logic                 mem_regwrite,
    input  logic [REG_BITS-1:0]  mem_dest,
    input  logic                 mem_is_load,
    input  logic                 mem_resp,
    input  logic [WIDTH-1:0]     mem_fwd,
    input  logic                 wb_valid,
    input  logic                 wb_regwrite,
    input  logic [REG_BITS-1:0]  wb_dest,
    input  logic [WIDTH-1:0]     wb_fwd,
    output logic [WIDTH-1:0]     ex_opA,
    output logic [WIDTH-1:0]     ex_opB,
    output logic                 ld_use_stall,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     hold_reg   [2];
    logic [1:0]           hold_v_reg;
    logic [CNT_WIDTH-1:0] stall_count_reg;

    // Per-operand views of the source side so both operands share one datapath
    logic [REG_BITS-1:0]  src_sel  [2];
    logic [1:0]           src_used;
    logic [WIDTH-1:0]     src_rf   [2];
    logic [WIDTH-1:0]     op       [2];
    logic [1:0]           mem_match;
    logic [1:0]           wb_match;

    assign src_sel[0] = ex_sr1;
    assign src_sel[1] = ex_sr2;
    assign src_used   = {ex_sr2_used, ex_sr1_used};
    assign src_rf[0]  = ex_rf_sr1;
    assign src_rf[1]  = ex_rf_sr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign mem_match[gi] = mem_valid & mem_regwrite & src_used[gi] &
                                   (mem_dest == src_sel[gi]);
            assign wb_match[gi]  = wb_valid & wb_regwrite & src_used[gi] &
                                   (wb_dest == src_sel[gi]);

            // MEM is the younger producer, so it wins over WB; the hold copy
            // only matters once neither live stage still supplies the value.
            assign op[gi] = mem_match[gi]  ? mem_fwd      :
                            wb_match[gi]   ? wb_fwd       :
                            hold_v_reg[gi] ? hold_reg[gi] :
                                             src_rf[gi];
        end
    endgenerate

    assign ex_opA = op[0];
    assign ex_opB = op[1];

    // The operand still shows mem_fwd during the hazard; EX must ignore it.
    assign ld_use_stall = ex_valid & mem_is_load & ~mem_resp & (|mem_match);

    assign stall_count = stall_count_reg;

    // Capture happens on entry to HOLD and on every HOLD edge with ex_hold
    // still set. Re-capturing the resolved operand (which may itself be the
    // hold copy) keeps a WB value alive after WB retires mid-hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            hold_reg[0]     <= '0;
            hold_reg[1]     <= '0;
            hold_v_reg      <= 2'b00;
            stall_count_reg <= '0;
        end else if (!pipe_stall) begin
            if (ld_use_stall && (stall_count_reg != {CNT_WIDTH{1'b1}})) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end

            case (state_reg)
                ST_RUN: begin
                    hold_v_reg <= 2'b00;
                    if (ex_valid && ex_hold) begin
                        state_reg   <= ST_HOLD;
                        hold_reg[0] <= op[0];
                        hold_reg[1] <= op[1];
                        hold_v_reg  <= 2'b11;
                    end
                end
                ST_HOLD: begin
                    if (ex_hold) begin
                        hold_reg[0] <= op[0];
                        hold_reg[1] <= op[1];
                        hold_v_reg  <= 2'b11;
                    end else begin
                        state_reg  <= ST_RUN;
                        hold_v_reg <= 2'b00;
                    end
                end
                default: begin
                    state_reg  <= ST_RUN;
                    hold_v_reg <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_operand_forwarder.sv
module tb_ex_operand_forwarder;

    logic        clk = 1'b0;
    logic        reset, pipe_stall, ex_hold, ex_valid;
    logic [2:0]  ex_sr1, ex_sr2, mem_dest, wb_dest;
    logic        ex_sr1_used, ex_sr2_used;
    logic [15:0] ex_rf_sr1, ex_rf_sr2, mem_fwd, wb_fwd;
    logic        mem_valid, mem_regwrite, mem_is_load, mem_resp;
    logic        wb_valid, wb_regwrite;
    logic [15:0] ex_opA, ex_opB;
    logic        ld_use_stall;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_operand_forwarder #(.WIDTH(16), .REG_BITS(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .pipe_stall(pipe_stall), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_sr1(ex_sr1), .ex_sr1_used(ex_sr1_used),
        .ex_sr2(ex_sr2), .ex_sr2_used(ex_sr2_used), .ex_rf_sr1(ex_rf_sr1),
        .ex_rf_sr2(ex_rf_sr2), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_dest(mem_dest), .mem_is_load(mem_is_load), .mem_resp(mem_resp),
        .mem_fwd(mem_fwd), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_dest(wb_dest), .wb_fwd(wb_fwd), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ld_use_stall(ld_use_stall), .stall_count(stall_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // EX either is in a hold window (holding copies of both operands) or not.
    bit          m_ok = 1'b0;
    bit          m_inhold;
    logic [15:0] m_heldA, m_heldB;
    int          m_cnt;

    function automatic bit f_mhit(input logic [2:0] s, input logic u);
        return mem_valid && mem_regwrite && u && (mem_dest == s);
    endfunction

    function automatic bit f_whit(input logic [2:0] s, input logic u);
        return wb_valid && wb_regwrite && u && (wb_dest == s);
    endfunction

    function automatic logic [15:0] f_op(input logic [2:0] s, input logic u,
                                         input logic [15:0] rf, input logic [15:0] held);
        if (f_mhit(s, u)) return mem_fwd;
        if (f_whit(s, u)) return wb_fwd;
        if (m_inhold)     return held;
        return rf;
    endfunction

    function automatic bit f_stall();
        return ex_valid && mem_is_load && !mem_resp &&
               (f_mhit(ex_sr1, ex_sr1_used) || f_mhit(ex_sr2, ex_sr2_used));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ok     <= 1'b1;
            m_inhold <= 1'b0;
            m_heldA  <= 16'h0;
            m_heldB  <= 16'h0;
            m_cnt    <= 0;
        end else if (m_ok && !pipe_stall) begin
            if (f_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (ex_hold && (m_inhold || ex_valid)) begin
                m_heldA  <= f_op(ex_sr1, ex_sr1_used, ex_rf_sr1, m_heldA);
                m_heldB  <= f_op(ex_sr2, ex_sr2_used, ex_rf_sr2, m_heldB);
                m_inhold <= 1'b1;
            end else begin
                m_inhold <= 1'b0;
            end
        end
    end

    // Per-cycle compare, on the falling edge away from input changes
    always @(negedge clk) begin
        if (m_ok) begin
            check("model_opA", ex_opA, f_op(ex_sr1, ex_sr1_used, ex_rf_sr1, m_heldA));
            check("model_opB", ex_opB, f_op(ex_sr2, ex_sr2_used, ex_rf_sr2, m_heldB));
            check("model_stall", ld_use_stall, f_stall());
            check("model_count", stall_count, m_cnt[15:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        pipe_stall = 0; ex_hold = 0; ex_valid = 1;
        ex_sr1 = 0; ex_sr1_used = 0; ex_sr2 = 0; ex_sr2_used = 0;
        ex_rf_sr1 = 0; ex_rf_sr2 = 0;
        mem_valid = 0; mem_regwrite = 0; mem_dest = 0; mem_is_load = 0;
        mem_resp = 0; mem_fwd = 0;
        wb_valid = 0; wb_regwrite = 0; wb_dest = 0; wb_fwd = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();

        // T1 reset
        ex_rf_sr1 = 16'h1234;
        tick(); tick();
        #1;
        check("t1_opA", ex_opA, 16'h1234);
        check("t1_count", stall_count, 16'h0000);
        reset = 0;

        // T2 priority
        tick();
        ex_sr1 = 3; ex_sr1_used = 1; ex_rf_sr1 = 16'h5555;
        mem_valid = 1; mem_regwrite = 1; mem_dest = 3; mem_fwd = 16'h1111;
        wb_valid = 1; wb_regwrite = 1; wb_dest = 3; wb_fwd = 16'h2222;
        #1; check("t2_mem_wins", ex_opA, 16'h1111);
        mem_regwrite = 0;
        #1; check("t2_wb", ex_opA, 16'h2222);
        wb_valid = 0;
        #1; check("t2_rf", ex_opA, 16'h5555);

        // T3 load-use
        tick();
        clear_inputs();
        mem_valid = 1; mem_regwrite = 1; mem_dest = 5; mem_is_load = 1; mem_resp = 0;
        ex_sr2 = 5; ex_sr2_used = 1; ex_rf_sr2 = 16'h0F0F;
        #1; check("t3_stall", ld_use_stall, 1'b1);
        tick(); tick(); tick();
        mem_resp = 1; mem_fwd = 16'hBEEF;
        #1;
        check("t3_count", stall_count, 16'd3);
        check("t3_stall_clear", ld_use_stall, 1'b0);
        check("t3_opB", ex_opB, 16'hBEEF);

        // T4 hold capture of a WB value that retires during the hold
        tick();
        clear_inputs();
        wb_valid = 1; wb_regwrite = 1; wb_dest = 2; wb_fwd = 16'hABCD;
        ex_sr1 = 2; ex_sr1_used = 1; ex_rf_sr1 = 16'h0000; ex_hold = 1;
        #1; check("t4_opA_wb", ex_opA, 16'hABCD);
        tick();
        wb_valid = 0;
        #1; check("t4_opA_held", ex_opA, 16'hABCD);
        tick();
        ex_hold = 0;
        #1; check("t4_opA_held2", ex_opA, 16'hABCD);
        tick();
        ex_rf_sr1 = 16'h4321;
        #1; check("t4_opA_run", ex_opA, 16'h4321);

        // T5 freeze while in HOLD with a load-use stall
        tick();
        clear_inputs();
        ex_sr1 = 2; ex_sr1_used = 1; ex_rf_sr1 = 16'h0A0A;
        ex_sr2 = 5; ex_sr2_used = 1; ex_rf_sr2 = 16'h0B0B;
        mem_valid = 1; mem_regwrite = 1; mem_dest = 5; mem_is_load = 1;
        mem_fwd = 16'h7777; ex_hold = 1;
        #1; check("t5_stall", ld_use_stall, 1'b1);
        tick();
        pipe_stall = 1; ex_rf_sr1 = 16'h1111;
        repeat (4) tick();
        #1;
        check("t5_count_frozen", stall_count, 16'd4);
        check("t5_holdA", ex_opA, 16'h0A0A);
        check("t5_stall_frozen", ld_use_stall, 1'b1);
        mem_valid = 0;
        #1; check("t5_holdB", ex_opB, 16'h7777);

        // T6 reset in the middle of HOLD, then counter saturation
        pipe_stall = 0;
        tick();
        reset = 1;
        tick();
        reset = 0; ex_rf_sr1 = 16'h2468; ex_rf_sr2 = 16'h1357;
        #1;
        check("t6_opA_after_reset", ex_opA, 16'h2468);
        check("t6_opB_after_reset", ex_opB, 16'h1357);
        check("t6_count_reset", stall_count, 16'h0000);
        ex_hold = 0; mem_valid = 1; mem_resp = 0;
        repeat (65534) tick();
        #1; check("t6_count_fffe", stall_count, 16'hFFFE);
        repeat (3) tick();
        #1; check("t6_count_sat", stall_count, 16'hFFFF);

        // Randomized phase against the model
        for (int i = 0; i < 2000; i++) begin
            tick();
            reset        = ($urandom_range(0, 59) == 0);
            pipe_stall   = ($urandom_range(0, 9) == 0);
            ex_hold      = ($urandom_range(0, 2) == 0);
            ex_valid     = ($urandom_range(0, 7) != 0);
            ex_sr1       = 3'($urandom_range(0, 3));
            ex_sr2       = 3'($urandom_range(0, 3));
            ex_sr1_used  = ($urandom_range(0, 4) != 0);
            ex_sr2_used  = ($urandom_range(0, 4) != 0);
            ex_rf_sr1    = 16'($urandom);
            ex_rf_sr2    = 16'($urandom);
            mem_valid    = ($urandom_range(0, 3) != 0);
            mem_regwrite = ($urandom_range(0, 3) != 0);
            mem_dest     = 3'($urandom_range(0, 3));
            mem_is_load  = ($urandom_range(0, 1) == 0);
            mem_resp     = ($urandom_range(0, 2) == 0);
            mem_fwd      = 16'($urandom);
            wb_valid     = ($urandom_range(0, 3) != 0);
            wb_regwrite  = ($urandom_range(0, 3) != 0);
            wb_dest      = 3'($urandom_range(0, 3));
            wb_fwd       = 16'($urandom);
        end
        tick();
        reset = 0;
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
